uart_rx_deserializer: RTL

Serial-to-parallel UART receiver that sits directly upstream of the UART full-duplex port of the single-cycle RISC-V SoC. It synchronizes the asynchronous `UART_Rx` pin, recovers 8N1 frames by mid-bit sampling, and hands each received byte to the memory-mapped UART port through a single-entry valid/ready holding register. Framing and overrun errors are reported as one-cycle status pulses.

---
 rtl/uart_rx_deserializer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the serial pin, samples each bit mid-period, and
// presents bytes through a single-entry valid/ready holding register with error pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       rx_busy_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             rx_meta_q, rx_s_q, rx_d_q;
  logic             fall_edge;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             oerr_q, oerr_d;
  logic             busy_q, busy_d;

  // Synchronizer and edge-delay flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign fall_edge = !rx_s_q && rx_d_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Leave at the stop-bit midpoint so the next start edge can be caught early.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!rx_s_q) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx_ready_i) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            oerr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign frame_err_o   = ferr_q;
  assign overrun_err_o = oerr_q;
  assign rx_busy_o     = busy_q;

endmodule
